// File: rtl/audio_rec_play_ctrl_if.sv
// FIFO-side bundle for the record/playback sequencer.
// fifo_wr/fifo_rd are single-cycle strobes, one per accepted sample; fifo_full/fifo_empty are levels sampled on the tick.
interface audio_rec_play_ctrl_if;
    logic fifo_wr;
    logic fifo_rd;
    logic fifo_full;
    logic fifo_empty;

    modport master (
        output fifo_wr,
        output fifo_rd,
        input  fifo_full,
        input  fifo_empty
    );

    modport slave (
        input  fifo_wr,
        input  fifo_rd,
        output fifo_full,
        output fifo_empty
    );
endinterface

// File: rtl/audio_rec_play_ctrl.sv
// Record/playback sequencer: debounced buttons and per-sample ticks become FIFO write/read strobes.
// Optional feature macro: MONITOR_PATH_EN (live mic-to-amp passthrough through the FIFO).
module audio_rec_play_ctrl #(
    parameter int          CNT_W       = 10,
    parameter int          MAX_SAMPLES = 1023,
    parameter logic [15:0] DEB_CYC     = 16'd50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 btn_rec,
    input  logic                 btn_play,
    audio_rec_play_ctrl_if.master fifo_bus,
    output logic                 amp_sd,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     sample_count,
    output logic                 run_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RECORD  = 2'b01,
        ST_PLAY    = 2'b10,
        ST_MONITOR = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_SAMPLES);
    localparam logic [CNT_W-1:0] PREFILL_CNT = CNT_W'(4);

    // Index 0 = record button, index 1 = play button.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       deb_prev;
    logic [1:0][15:0] deb_cnt;

    logic   rec_ev;
    logic   play_ev;
    logic   mon_ev;
    state_t st;
    logic [CNT_W-1:0] cnt;
    logic   wr_q;
    logic   rd_q;
    logic   amp_q;
    logic   done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= {btn_play, btn_rec};
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_CYC - 16'd1) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign rec_ev  = deb[0] & ~deb_prev[0];
    assign play_ev = deb[1] & ~deb_prev[1];

`ifdef MONITOR_PATH_EN
    assign mon_ev = rec_ev & play_ev;
`else
    assign mon_ev = 1'b0;
`endif

    // A tick seen in the same cycle as the start event is dropped: the run has not begun yet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= ST_IDLE;
            cnt    <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            amp_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            case (st)
                ST_IDLE: begin
                    amp_q <= 1'b0;
                    if (mon_ev) begin
                        st    <= ST_MONITOR;
                        cnt   <= '0;
                        amp_q <= 1'b1;
                    end else if (rec_ev) begin
                        st  <= ST_RECORD;
                        cnt <= '0;
                    end else if (play_ev && !fifo_bus.fifo_empty) begin
                        st    <= ST_PLAY;
                        cnt   <= '0;
                        amp_q <= 1'b1;
                    end
                end
                ST_RECORD: begin
                    if (rec_ev) begin
                        st     <= ST_IDLE;
                        done_q <= 1'b1;
                    end else if (sample_tick) begin
                        if (fifo_bus.fifo_full || cnt >= MAX_CNT) begin
                            st     <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            wr_q <= 1'b1;
                            cnt  <= cnt + 1'b1;
                            if (cnt == MAX_CNT - 1'b1) begin
                                st     <= ST_IDLE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_PLAY: begin
                    if (play_ev) begin
                        st     <= ST_IDLE;
                        done_q <= 1'b1;
                        amp_q  <= 1'b0;
                    end else if (sample_tick) begin
                        if (fifo_bus.fifo_empty) begin
                            st     <= ST_IDLE;
                            done_q <= 1'b1;
                            amp_q  <= 1'b0;
                        end else begin
                            rd_q <= 1'b1;
                            if (~&cnt) cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_MONITOR: begin
`ifdef MONITOR_PATH_EN
                    if (rec_ev || play_ev) begin
                        st     <= ST_IDLE;
                        done_q <= 1'b1;
                        amp_q  <= 1'b0;
                    end else if (sample_tick) begin
                        // Reads start only after a few samples are buffered.
                        wr_q <= 1'b1;
                        if (cnt >= PREFILL_CNT) rd_q <= 1'b1;
                        if (~&cnt) cnt <= cnt + 1'b1;
                    end
`else
                    st    <= ST_IDLE;
                    amp_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign fifo_bus.fifo_wr = wr_q;
    assign fifo_bus.fifo_rd = rd_q;
    assign amp_sd           = amp_q;
    assign state            = st;
    assign sample_count     = cnt;
    assign run_done         = done_q;

endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// Directed bench for audio_rec_play_ctrl with short debounce and 8-sample record limit.
// Builds with or without MONITOR_PATH_EN; the both-button sequence adapts to the build.
module tb_audio_rec_play_ctrl;

    localparam int CNT_W = 10;

    logic             clk;
    logic             reset;
    logic             sample_tick;
    logic             btn_rec;
    logic             btn_play;
    logic             amp_sd;
    logic [1:0]       state;
    logic [CNT_W-1:0] sample_count;
    logic             run_done;

    audio_rec_play_ctrl_if fifo_bus();

    audio_rec_play_ctrl #(
        .CNT_W      (CNT_W),
        .MAX_SAMPLES(8),
        .DEB_CYC    (16'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .btn_rec     (btn_rec),
        .btn_play    (btn_play),
        .fifo_bus    (fifo_bus),
        .amp_sd      (amp_sd),
        .state       (state),
        .sample_count(sample_count),
        .run_done    (run_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;
    logic tick_last  = 1'b0;
    logic allow_both = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse bookkeeping: every strobe must follow a tick by exactly one cycle.
    always @(negedge clk) begin
        if (fifo_bus.fifo_wr || fifo_bus.fifo_rd) begin
            check("pulse_latency", tick_last, 1'b1);
            if (!allow_both) check("wr_rd_exclusive", fifo_bus.fifo_wr & fifo_bus.fifo_rd, 1'b0);
        end
        if (fifo_bus.fifo_wr) wr_cnt++;
        if (fifo_bus.fifo_rd) rd_cnt++;
        if (run_done) done_cnt++;
        tick_last = sample_tick;
    end

    task automatic clear_counts();
        wr_cnt   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic press(input logic r, input logic p);
        @(posedge clk); #1;
        btn_rec  = r;
        btn_play = p;
        repeat (12) @(posedge clk);
        #1;
        btn_rec  = 1'b0;
        btn_play = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        @(posedge clk); #1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic is_play;
        int   n_ticks;
        int   flag_at;
        logic stop_press;
        int   exp_pulses;
        int   exp_count;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v, input int idx);
        fifo_bus.fifo_full  = 1'b0;
        fifo_bus.fifo_empty = 1'b0;
        clear_counts();
        press(!v.is_play, v.is_play);
        check($sformatf("vec%0d_run_state", idx), state, v.is_play ? 2'b10 : 2'b01);
        check($sformatf("vec%0d_run_amp", idx), amp_sd, v.is_play);
        for (int k = 1; k <= v.n_ticks; k++) begin
            if (k == v.flag_at) begin
                if (v.is_play) fifo_bus.fifo_empty = 1'b1;
                else           fifo_bus.fifo_full  = 1'b1;
            end
            do_tick();
        end
        if (v.stop_press) press(!v.is_play, v.is_play);
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("vec%0d_end_state", idx), state, 2'b00);
        check($sformatf("vec%0d_end_amp", idx), amp_sd, 1'b0);
        check($sformatf("vec%0d_pulses", idx), v.is_play ? rd_cnt : wr_cnt, v.exp_pulses);
        check($sformatf("vec%0d_other_pulses", idx), v.is_play ? wr_cnt : rd_cnt, 0);
        check($sformatf("vec%0d_count", idx), sample_count, v.exp_count);
        check($sformatf("vec%0d_run_done", idx), done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          play  ticks flag stop pulses count
        vecs[0] = '{1'b0, 10,   0,   1'b0, 8,  8};
        vecs[1] = '{1'b0, 10,   3,   1'b0, 2,  2};
        vecs[2] = '{1'b0, 4,    1,   1'b0, 0,  0};
        vecs[3] = '{1'b0, 10,   8,   1'b0, 7,  7};
        vecs[4] = '{1'b0, 3,    0,   1'b1, 3,  3};
        vecs[5] = '{1'b1, 8,    6,   1'b0, 5,  5};
        vecs[6] = '{1'b1, 3,    1,   1'b0, 0,  0};
        vecs[7] = '{1'b1, 12,   11,  1'b0, 10, 10};
        vecs[8] = '{1'b1, 4,    0,   1'b1, 4,  4};

        reset               = 1'b0;
        sample_tick         = 1'b0;
        btn_rec             = 1'b0;
        btn_play            = 1'b0;
        fifo_bus.fifo_full  = 1'b0;
        fifo_bus.fifo_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", state, 2'b00);
        check("reset_wr", fifo_bus.fifo_wr, 1'b0);
        check("reset_rd", fifo_bus.fifo_rd, 1'b0);
        check("reset_amp", amp_sd, 1'b0);
        check("reset_count", sample_count, 0);
        check("reset_done", run_done, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Short bounces never satisfy the stability window.
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            btn_rec = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            btn_rec = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        repeat (12) @(posedge clk);
        #1;
        check("bounce_state", state, 2'b00);
        check("bounce_done", done_cnt, 0);

        fifo_bus.fifo_empty = 1'b1;
        press(1'b0, 1'b1);
        check("play_empty_state", state, 2'b00);
        check("play_empty_amp", amp_sd, 1'b0);
        fifo_bus.fifo_empty = 1'b0;

        clear_counts();
`ifdef MONITOR_PATH_EN
        allow_both = 1'b1;
        press(1'b1, 1'b1);
        check("both_state", state, 2'b11);
        check("mon_amp", amp_sd, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            sample_tick = 1'b1;
            @(posedge clk); #1;
            sample_tick = 1'b0;
            check($sformatf("mon_tick%0d_wr", k), fifo_bus.fifo_wr, 1'b1);
            check($sformatf("mon_tick%0d_rd", k), fifo_bus.fifo_rd, (k >= 5));
            repeat (2) @(posedge clk);
            #1;
        end
        press(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mon_end_state", state, 2'b00);
        check("mon_end_amp", amp_sd, 1'b0);
        check("mon_done", done_cnt, 1);
        check("mon_count", sample_count, 6);
        check("mon_wr_total", wr_cnt, 6);
        check("mon_rd_total", rd_cnt, 2);
        allow_both = 1'b0;
`else
        press(1'b1, 1'b1);
        check("both_state", state, 2'b01);
        do_tick();
        do_tick();
        press(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("both_end_state", state, 2'b00);
        check("both_done", done_cnt, 1);
        check("both_wr", wr_cnt, 2);
        check("both_rd", rd_cnt, 0);
        check("both_count", sample_count, 2);
`endif

        // Asynchronous reset while a read strobe is on the wire.
        fifo_bus.fifo_empty = 1'b0;
        press(1'b0, 1'b1);
        check("rst_play_state", state, 2'b10);
        @(posedge clk); #1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        check("rst_pre_rd", fifo_bus.fifo_rd, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_state", state, 2'b00);
        check("rst_amp", amp_sd, 1'b0);
        check("rst_rd", fifo_bus.fifo_rd, 1'b0);
        check("rst_count", sample_count, 0);
        do_tick();
        check("rst_hold_state", state, 2'b00);
        check("rst_hold_amp", amp_sd, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_release_state", state, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
